uart_tx_fifo: RTL and testbench
===============================

# uart_tx_fifo

Byte buffer directly upstream of the UART transmitter. Host-side logic pushes bytes with a valid/ready handshake; the FIFO releases one byte per transmitter slot, paced by the `intx` tick from the baud generator. The block presents the byte on `data_out` with a one-cycle `tx_load` strobe. This decouples bursty producers from the fixed baud rate.

## Interface
Parameters:
- `DEPTH`, 8, number of byte entries; power of two, minimum 2.
- `ADDR_W`, 3, pointer width; equals log2(`DEPTH`).

Ports:
- `clk`  in  1  single clock; all state updates on its rising edge.
- `reset`  in  1  asynchronous, active-high reset.
- `wr_data`  in  8  byte offered by the producer.
- `wr_valid`  in  1  producer offers `wr_data` this cycle.
- `wr_ready`  out  1  FIFO can accept a byte this cycle; equals `!full`.
- `intx`  in  1  one-cycle transmitter-slot tick from the baud generator.
- `data_out`  out  8  registered byte handed to the transmitter `data_in`.
- `tx_load`  out  1  one-cycle strobe: `data_out` is new this cycle.
- `empty`  out  1  count == 0.
- `full`  out  1  count == `DEPTH`.
- `count`  out  `ADDR_W+1`  current occupancy, 0..`DEPTH`.
- `overflow`  out  1  sticky dropped-write flag; see Configuration.

## Operation
- Storage: `DEPTH` x 8 array, write pointer `wr_ptr`, read pointer `rd_ptr`, and occupancy `count`. Both pointers are `ADDR_W` bits and wrap naturally from `DEPTH-1` to 0.
- Push: `wr_valid && wr_ready` writes `mem[wr_ptr] <= wr_data` and increments `wr_ptr`.
- Pop: `intx && !empty` performs the following on the same edge:
  - `data_out <= mem[rd_ptr]`
  - `rd_ptr` increments
  - `tx_load <= 1`
- `tx_load` is 0 on every other cycle. `data_out` holds its last value when there is no pop.
- Tick while empty: no pop, `tx_load` stays 0, and the slot is skipped. Ticks are not queued.
- Count update: +1 on push only, -1 on pop only, unchanged when both or neither occur.
- Full FIFO with a pop in the same cycle: `wr_ready` is derived from the registered count, so it is 0 and the write is refused. The space becomes visible the next cycle.
- Empty FIFO with a push in the same cycle as `intx`: no pop occurs. The byte is popped on the next `intx`.
- `wr_valid` while full: the byte is dropped, and the pointers and count are unchanged.
- Reset values, applied asynchronously:
  - `wr_ptr`, `rd_ptr`, `count` = 0
  - `data_out` = 8'h00
  - `tx_load` = 0
  - `overflow` = 0
  - `empty` = 1, `full` = 0, `wr_ready` = 1
- Array contents are not reset.
- Reset mid-operation discards all buffered bytes immediately. Any `tx_load` pulse in flight is cut.

## Timing
- Push-to-visible latency: a byte accepted at edge N can be popped by an `intx` sampled at edge N+1 or later.
- Pop latency: with `intx` high at edge N, `data_out` and `tx_load` are valid immediately after edge N, for exactly one cycle of `tx_load`.
- Back-to-back pops on consecutive `intx` cycles are supported, giving one byte per tick.
- `wr_ready`, `empty`, `full` and `count` are functions of registers only. There is no combinational path from `wr_valid` or `intx` to any output.
- Sustained throughput: one push per cycle into a non-full FIFO, and one pop per `intx`.

## Configuration
- Macro: `UART_TX_FIFO_OVF_EN`.
- Defined: `overflow` sets to 1 on the edge where `wr_valid && full`. It stays 1 until `reset`.
- Undefined: `overflow` is tied to 0 and no flag register is built.
- Data-path behaviour is identical in both cases; a dropped write is still dropped.

## Structure
- Shared package `uart_pkg` holds:
  - `UART_DATA_W = 8`
  - `UART_FRAME_W = 11`
  - `UART_FIFO_DEPTH = 8`
- The transmitter, receiver and this block all import the package.
- Sub-module `uart_fifo_mem`: a simple dual-port register array (write port, asynchronous read address, registered read in the parent), parameterised by `DEPTH` and `ADDR_W`.
- Pointer, count and handshake logic stay in `uart_tx_fifo`.

## Test plan
- Reset release → `empty`=1, `wr_ready`=1, `count`=0, `data_out`=8'h00, `tx_load`=0.
- Push 8'hA5, 8'h3C, then three `intx` pulses two cycles apart → `tx_load` pulses twice with `data_out` = A5 then 3C. The third tick gives `tx_load`=0 with `data_out` held at 3C.
- Push 9 bytes 8'h01..8'h09 with no `intx` → results:
  - `full`=1 after the eighth push, and `count`=8.
  - The ninth push is dropped.
  - `overflow`=1 with `UART_TX_FIFO_OVF_EN` defined, and 0 without it.
  - Subsequent pops return 01..08.
- Full FIFO with `wr_valid` and `intx` high in the same cycle → the write is refused, `count`=7, the popped byte is 8'h01, and `wr_ready`=1 next cycle.
- Wrap-around: 20 interleaved pushes and pops of 8'h10..8'h23 with occupancy kept at 3–6 → output order matches input order exactly.
- Assert `reset` mid-stream while `count`=5 → all state is cleared asynchronously. After release, a push of 8'h77 followed by one `intx` yields `data_out`=8'h77.

Source files
------------

// File: rtl/uart_pkg.sv
// Shared UART package: data/frame widths, FIFO depth and byte helpers used
// by the transmitter, receiver and transmit FIFO.
package uart_pkg;

    localparam int UART_DATA_W     = 8;
    localparam int UART_FRAME_W    = 11;
    localparam int UART_FIFO_DEPTH = 8;

    typedef logic [UART_DATA_W-1:0] uart_byte_t;

    // Even parity of one data byte (shared by transmitter and receiver framing)
    function automatic logic uart_byte_parity(input uart_byte_t b);
        return ^b;
    endfunction

endpackage

// File: rtl/uart_fifo_mem.sv
// Simple dual-port byte array for the UART FIFOs: one synchronous write
// port and an asynchronous read address. The read data is registered by
// the parent, so this block holds storage only. Contents are never reset.
module uart_fifo_mem
    import uart_pkg::*;
#(
    parameter int DEPTH  = UART_FIFO_DEPTH,
    parameter int ADDR_W = 3
) (
    input  logic                   clk,
    input  logic                   we,
    input  logic [ADDR_W-1:0]      waddr,
    input  logic [UART_DATA_W-1:0] wdata,
    input  logic [ADDR_W-1:0]      raddr,
    output logic [UART_DATA_W-1:0] rdata
);

    logic [UART_DATA_W-1:0] mem_r [DEPTH];

    // Store the accepted byte at the write address
    always_ff @(posedge clk) begin
        if (we) begin
            mem_r[waddr] <= wdata;
        end
    end

    assign rdata = mem_r[raddr];

endmodule

// File: rtl/uart_tx_fifo.sv
// Transmit byte FIFO feeding the UART transmitter. Bytes enter through a
// valid/ready handshake and leave one per baud-generator slot (intx) with a
// one-cycle tx_load strobe on a registered data_out.
// Optional feature: define UART_TX_FIFO_OVF_EN to build the sticky
// overflow flag; otherwise overflow is tied low.
module uart_tx_fifo
    import uart_pkg::*;
#(
    parameter int DEPTH  = UART_FIFO_DEPTH,
    parameter int ADDR_W = 3
) (
    input  logic                   clk,
    input  logic                   reset,
    input  logic [UART_DATA_W-1:0] wr_data,
    input  logic                   wr_valid,
    output logic                   wr_ready,
    input  logic                   intx,
    output logic [UART_DATA_W-1:0] data_out,
    output logic                   tx_load,
    output logic                   empty,
    output logic                   full,
    output logic [ADDR_W:0]        count,
    output logic                   overflow
);

    localparam logic [ADDR_W:0]   COUNT_FULL = (ADDR_W+1)'(DEPTH);
    localparam logic [ADDR_W:0]   COUNT_ONE  = (ADDR_W+1)'(1);
    localparam logic [ADDR_W-1:0] PTR_ONE    = ADDR_W'(1);

    logic [ADDR_W-1:0]      wr_ptr_r;
    logic [ADDR_W-1:0]      rd_ptr_r;
    logic [ADDR_W:0]        count_r;
    logic [UART_DATA_W-1:0] data_out_r;
    logic                   tx_load_r;
    logic [UART_DATA_W-1:0] rd_data_s;
    logic                   empty_s;
    logic                   full_s;
    logic                   push_s;
    logic                   pop_s;

    // Status flags come from the registered occupancy only, so a same-cycle
    // pop never opens space for a write on a full FIFO.
    assign empty_s = (count_r == {(ADDR_W+1){1'b0}});
    assign full_s  = (count_r == COUNT_FULL);

    // Handshake qualification: accept when not full, release when a slot
    // tick arrives and a byte is already stored (a same-cycle push waits).
    always_comb begin
        push_s = 1'b0;
        pop_s  = 1'b0;
        if (wr_valid && !full_s) begin
            push_s = 1'b1;
        end else begin
            push_s = 1'b0;
        end
        if (intx && !empty_s) begin
            pop_s = 1'b1;
        end else begin
            pop_s = 1'b0;
        end
    end

    uart_fifo_mem #(
        .DEPTH  (DEPTH),
        .ADDR_W (ADDR_W)
    ) u_mem (
        .clk   (clk),
        .we    (push_s),
        .waddr (wr_ptr_r),
        .wdata (wr_data),
        .raddr (rd_ptr_r),
        .rdata (rd_data_s)
    );

    // Write pointer advances on every accepted byte
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            wr_ptr_r <= {ADDR_W{1'b0}};
        end else if (push_s) begin
            wr_ptr_r <= wr_ptr_r + PTR_ONE;
        end
    end

    // Read pointer, registered output byte and load strobe on each pop
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            rd_ptr_r   <= {ADDR_W{1'b0}};
            data_out_r <= 8'h00;
            tx_load_r  <= 1'b0;
        end else if (pop_s) begin
            rd_ptr_r   <= rd_ptr_r + PTR_ONE;
            data_out_r <= rd_data_s;
            tx_load_r  <= 1'b1;
        end else begin
            tx_load_r  <= 1'b0;
        end
    end

    // Occupancy: simultaneous push and pop cancel out
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            count_r <= {(ADDR_W+1){1'b0}};
        end else if (push_s && !pop_s) begin
            count_r <= count_r + COUNT_ONE;
        end else if (pop_s && !push_s) begin
            count_r <= count_r - COUNT_ONE;
        end
    end

`ifdef UART_TX_FIFO_OVF_EN
    logic overflow_r;

    // Sticky flag: remembers any write offered while the FIFO was full
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            overflow_r <= 1'b0;
        end else if (wr_valid && full_s) begin
            overflow_r <= 1'b1;
        end
    end

    assign overflow = overflow_r;
`else
    assign overflow = 1'b0;
`endif

    assign wr_ready = !full_s;
    assign empty    = empty_s;
    assign full     = full_s;
    assign count    = count_r;
    assign data_out = data_out_r;
    assign tx_load  = tx_load_r;

endmodule

// File: tb/tb_uart_tx_fifo.sv
// Self-checking bench for uart_tx_fifo: directed steps plus randomized
// traffic, compared every cycle against a queue-based reference model.
module tb_uart_tx_fifo;

    localparam int DEPTH  = 8;
    localparam int ADDR_W = 3;

    logic              clk;
    logic              reset;
    logic [7:0]        wr_data;
    logic              wr_valid;
    logic              wr_ready;
    logic              intx;
    logic [7:0]        data_out;
    logic              tx_load;
    logic              empty;
    logic              full;
    logic [ADDR_W:0]   count;
    logic              overflow;

    int tests;
    int fails;

    // Reference model: ordered queue of stored bytes plus expected outputs
    logic [7:0] mq[$];
    logic [7:0] exp_data;
    logic       exp_load;
    logic       exp_ovf;
    logic [7:0] got[$];

    uart_tx_fifo #(.DEPTH(DEPTH), .ADDR_W(ADDR_W)) dut (
        .clk      (clk),
        .reset    (reset),
        .wr_data  (wr_data),
        .wr_valid (wr_valid),
        .wr_ready (wr_ready),
        .intx     (intx),
        .data_out (data_out),
        .tx_load  (tx_load),
        .empty    (empty),
        .full     (full),
        .count    (count),
        .overflow (overflow)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        tests++;
        assert (obs === exp) else begin
            fails++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic check_all(input string tag);
        check({tag, ".tx_load"},  {31'd0, tx_load},  {31'd0, exp_load});
        check({tag, ".data_out"}, {24'd0, data_out}, {24'd0, exp_data});
        check({tag, ".count"},    {28'd0, count},    32'(mq.size()));
        check({tag, ".empty"},    {31'd0, empty},    {31'd0, (mq.size() == 0)});
        check({tag, ".full"},     {31'd0, full},     {31'd0, (mq.size() == DEPTH)});
        check({tag, ".wr_ready"}, {31'd0, wr_ready}, {31'd0, (mq.size() != DEPTH)});
        check({tag, ".overflow"}, {31'd0, overflow}, {31'd0, exp_ovf});
    endtask

    // One clock: drive inputs, take the edge, advance the model, compare
    task automatic step(input string tag, input logic wv, input logic [7:0] wd, input logic tk);
        bit was_full;
        bit do_push;
        bit do_pop;
        wr_valid = wv;
        wr_data  = wd;
        intx     = tk;
        @(posedge clk);
        #1;
        was_full = (mq.size() == DEPTH);
        do_push  = wv && !was_full;
        do_pop   = tk && (mq.size() != 0);
`ifdef UART_TX_FIFO_OVF_EN
        if (wv && was_full) exp_ovf = 1'b1;
`endif
        exp_load = do_pop;
        if (do_pop) exp_data = mq.pop_front();
        if (do_push) mq.push_back(wd);
        check_all(tag);
        if (tx_load) got.push_back(data_out);
        wr_valid = 1'b0;
        intx     = 1'b0;
    endtask

    initial begin
        int idx;
        bit pv;
        bit tk;
        tests    = 0;
        fails    = 0;
        exp_data = 8'h00;
        exp_load = 1'b0;
        exp_ovf  = 1'b0;
        reset    = 1'b1;
        wr_valid = 1'b0;
        wr_data  = 8'h00;
        intx     = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        reset = 1'b0;
        check_all("reset");

        // Two bytes out over three spaced ticks; the third tick finds it empty
        step("push_a5", 1'b1, 8'hA5, 1'b0);
        step("push_3c", 1'b1, 8'h3C, 1'b0);
        step("tick1", 1'b0, 8'h00, 1'b1);
        check("tick1_byte", {24'd0, data_out}, 32'h0000_00A5);
        step("gap1", 1'b0, 8'h00, 1'b0);
        step("tick2", 1'b0, 8'h00, 1'b1);
        check("tick2_byte", {24'd0, data_out}, 32'h0000_003C);
        step("gap2", 1'b0, 8'h00, 1'b0);
        step("tick3_empty", 1'b0, 8'h00, 1'b1);
        check("tick3_hold", {24'd0, data_out}, 32'h0000_003C);

        // Fill past capacity; the ninth byte is dropped
        for (int i = 1; i <= 9; i++) step("fill", 1'b1, 8'(i), 1'b0);
        check("fill_count", {28'd0, count}, 32'd8);
        check("fill_full", {31'd0, full}, 32'd1);

        // Full with write and tick together: write refused, 01 popped
        step("full_pop", 1'b1, 8'hEE, 1'b1);
        check("full_pop_byte", {24'd0, data_out}, 32'h0000_0001);
        check("full_pop_count", {28'd0, count}, 32'd7);
        step("space_seen", 1'b0, 8'h00, 1'b0);
        check("space_ready", {31'd0, wr_ready}, 32'd1);

        // Drain the rest: 02..08 in order
        got.delete();
        for (int i = 0; i < 7; i++) step("drain", 1'b0, 8'h00, 1'b1);
        for (int i = 0; i < 7; i++) check("drain_order", 32'(got[i]), 32'(i + 2));

        // Push and tick together on an empty FIFO: pop only on the next tick
        step("empty_push_tick", 1'b1, 8'h5A, 1'b1);
        step("next_tick", 1'b0, 8'h00, 1'b1);

        // Wrap-around: 10..23 with occupancy held at 3..6
        got.delete();
        idx = 0;
        for (int i = 0; i < 3; i++) begin
            step("wrap_prime", 1'b1, 8'(8'h10 + idx), 1'b0);
            idx++;
        end
        for (int c = 0; c < 200 && got.size() < 20; c++) begin
            pv = (idx < 20) && ((mq.size() < 3) || ((mq.size() < 6) && ($urandom_range(0, 1) == 1)));
            tk = (mq.size() > 3) || ((idx >= 20) && (mq.size() > 0)) || (pv && ($urandom_range(0, 1) == 1));
            step("wrap", pv, 8'(8'h10 + idx), tk);
            if (pv) idx++;
        end
        check("wrap_total", 32'(got.size()), 32'd20);
        for (int i = 0; i < 20 && i < got.size(); i++) check("wrap_order", 32'(got[i]), 32'(8'h10 + i));

        // Randomized traffic
        for (int c = 0; c < 150; c++) begin
            step("rand", 1'($urandom_range(0, 1)), 8'($urandom), ($urandom_range(0, 2) == 0));
        end
        for (int c = 0; c < 10; c++) step("rand_drain", 1'b0, 8'h00, 1'b1);

        // Reset mid-stream with count at 5 and a load strobe in flight
        for (int i = 0; i < 6; i++) step("pre_rst", 1'b1, 8'(8'hC0 + i), 1'b0);
        step("pre_rst_pop", 1'b0, 8'h00, 1'b1);
        check("pre_rst_count", {28'd0, count}, 32'd5);
        #2;
        reset = 1'b1;
        #1;
        mq.delete();
        exp_data = 8'h00;
        exp_load = 1'b0;
        exp_ovf  = 1'b0;
        check_all("async_rst");
        @(posedge clk);
        #1;
        reset = 1'b0;
        step("post_rst_push", 1'b1, 8'h77, 1'b0);
        step("post_rst_tick", 1'b0, 8'h00, 1'b1);
        check("post_rst_byte", {24'd0, data_out}, 32'h0000_0077);

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
